// File: rtl/mips_cpu_data_bus_bridge_if.sv
// Pipelined wait-state memory bus between the CPU data bridge (master) and memory (slave).
interface mips_cpu_data_bus_bridge_if;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic        avm_write;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
    output avm_waitrequest, avm_readdatavalid, avm_readdata
  );
endinterface

// File: rtl/mips_cpu_data_bus_bridge.sv
// Turns each CPU data access into one bus transaction and stalls the core via
// cpu_clk_enable until the result is ready in the hold register.
module mips_cpu_data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_READDATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ext_clk_enable,
  input  logic        cpu_active,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_address,
  input  logic [3:0]  cpu_data_byteenable,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic        bus_error,
  mips_cpu_data_bus_bridge_if.master avm
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RD_WAIT, S_DONE} state_t;

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_read;
  logic [31:0]        r_hold;
  logic               r_bus_error;
  logic [31:0]        r_address;
  logic [3:0]         r_byteenable;
  logic [31:0]        r_writedata;
  logic               r_read;
  logic               r_write;

  logic w_req;
  logic w_timeout;
  logic w_clk_en;

  assign w_req     = cpu_active & (cpu_data_read | cpu_data_write);
  assign w_timeout = (r_cnt >= CNT_LAST);

  always_comb begin
    // NOTE: default assigned first so no path leaves w_clk_en unassigned (no latch).
    w_clk_en = 1'b0;
    case (r_state)
      S_IDLE:  w_clk_en = ext_clk_enable & ~w_req;
      S_DONE:  w_clk_en = ext_clk_enable;
      default: w_clk_en = 1'b0;
    endcase
  end

  // The core must never advance while the bridge is held in reset.
  assign cpu_clk_enable     = reset_n & w_clk_en;
  assign cpu_data_readdata  = r_hold;
  assign bus_error          = r_bus_error;
  assign avm.avm_address    = r_address;
  assign avm.avm_byteenable = r_byteenable;
  assign avm.avm_writedata  = r_writedata;
  assign avm.avm_read       = r_read;
  assign avm.avm_write      = r_write;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_is_read    <= 1'b0;
      r_hold       <= '0;
      r_bus_error  <= 1'b0;
      r_address    <= '0;
      r_byteenable <= '0;
      r_writedata  <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && ext_clk_enable) begin
            r_address    <= cpu_data_address;
            r_byteenable <= cpu_data_byteenable;
            r_writedata  <= cpu_data_writedata;
            // A read+write collision is performed as the write alone.
            r_write      <= cpu_data_write;
            r_read       <= ~cpu_data_write;
            r_is_read    <= ~cpu_data_write;
            r_cnt        <= '0;
            if (cpu_data_read && cpu_data_write) begin
              r_bus_error <= 1'b1;
              r_hold      <= '0;
            end
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!avm.avm_waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            if (!r_is_read) begin
              r_state <= S_DONE;
            end else if (avm.avm_readdatavalid) begin
              r_hold  <= avm.avm_readdata;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end else if (w_timeout) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_bus_error <= 1'b1;
            if (r_is_read) r_hold <= ERR_READDATA;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (avm.avm_readdatavalid) begin
            r_hold  <= avm.avm_readdata;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_hold      <= ERR_READDATA;
            r_bus_error <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // Hold the result until the core has actually taken its update edge.
          if (ext_clk_enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_data_bus_bridge.sv
// Directed bench for mips_cpu_data_bus_bridge: per-cycle vector tables plus
// hand-written timeout and asynchronous-reset sequences.
module tb_mips_cpu_data_bus_bridge;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] BAD = 32'h0BAD0BAD;

  logic        clk;
  logic        reset_n;
  logic        ext_clk_enable;
  logic        cpu_active;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_address;
  logic [3:0]  cpu_data_byteenable;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic        bus_error;

  int n_checks = 0;
  int n_errors = 0;

  mips_cpu_data_bus_bridge_if bus ();

  mips_cpu_data_bus_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_READDATA  (32'hDEADBEEF)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ext_clk_enable     (ext_clk_enable),
    .cpu_active         (cpu_active),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_write     (cpu_data_write),
    .cpu_data_address   (cpu_data_address),
    .cpu_data_byteenable(cpu_data_byteenable),
    .cpu_data_writedata (cpu_data_writedata),
    .cpu_data_readdata  (cpu_data_readdata),
    .cpu_clk_enable     (cpu_clk_enable),
    .bus_error          (bus_error),
    .avm                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ext, act, rd, wr;
    logic [31:0] addr, wd;
    logic        wt, rv;
    logic [31:0] rdat;
    logic        e_en, e_rd, e_wr;
    logic [31:0] e_addr, e_wd, e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ext, act, rd, wr, input logic [31:0] addr, wd,
                              input logic wt, rv, input logic [31:0] rdat,
                              input logic e_en, e_rd, e_wr, input logic [31:0] e_addr, e_wd, e_rdata,
                              input logic e_err);
    vec_t v;
    v.ext = ext; v.act = act; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.wt = wt; v.rv = rv; v.rdat = rdat;
    v.e_en = e_en; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Each vector: inputs held for one clock cycle, outputs checked mid-cycle.
  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      @(posedge clk); #1;
      ext_clk_enable         = vq[i].ext;
      cpu_active             = vq[i].act;
      cpu_data_read          = vq[i].rd;
      cpu_data_write         = vq[i].wr;
      cpu_data_address       = vq[i].addr;
      cpu_data_writedata     = vq[i].wd;
      bus.avm_waitrequest    = vq[i].wt;
      bus.avm_readdatavalid  = vq[i].rv;
      bus.avm_readdata       = vq[i].rdat;
      #1;
      check1($sformatf("%s[%0d].clk_enable", tag, i), cpu_clk_enable, vq[i].e_en);
      check1($sformatf("%s[%0d].avm_read", tag, i), bus.avm_read, vq[i].e_rd);
      check1($sformatf("%s[%0d].avm_write", tag, i), bus.avm_write, vq[i].e_wr);
      check($sformatf("%s[%0d].avm_address", tag, i), bus.avm_address, vq[i].e_addr);
      check($sformatf("%s[%0d].avm_writedata", tag, i), bus.avm_writedata, vq[i].e_wd);
      check($sformatf("%s[%0d].readdata", tag, i), cpu_data_readdata, vq[i].e_rdata);
      check1($sformatf("%s[%0d].bus_error", tag, i), bus_error, vq[i].e_err);
      if (vq[i].e_rd || vq[i].e_wr)
        check($sformatf("%s[%0d].avm_byteenable", tag, i), {28'h0, bus.avm_byteenable}, 32'h0000000F);
    end
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    ext_clk_enable = 1'b1;
    cpu_active = 1'b1;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    cpu_data_address = 32'h0;
    cpu_data_byteenable = 4'hF;
    cpu_data_writedata = 32'h0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = 32'h0;

    // Reset state, with ext_clk_enable high to show the enable is forced low.
    #2 reset_n = 1'b0;
    #1;
    check1("rst.clk_enable", cpu_clk_enable, N);
    check1("rst.avm_read", bus.avm_read, N);
    check1("rst.avm_write", bus.avm_write, N);
    check("rst.avm_address", bus.avm_address, 32'h0);
    check("rst.readdata", cpu_data_readdata, 32'h0);
    check1("rst.bus_error", bus_error, N);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Zero-wait write, run-enable gating, wait-state read, DONE hold, back-to-back, accept-cycle data.
    //                    ext act rd wr addr          wd            wt rv rdat            en rd wr e_addr        e_wd          e_rdata       err
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h0,       32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, N, Y, 32'h1000,    32'h12345678, N, N, BAD,          N, N, N, 32'h0,       32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, N, Y, 32'h1000,    32'h12345678, N, N, BAD,          N, N, Y, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(Y, Y, N, Y, 32'h1000,    32'h12345678, N, N, BAD,          Y, N, N, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(N, Y, Y, N, 32'h8000,    32'h0,        N, N, BAD,          N, N, N, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(N, Y, Y, N, 32'h8000,    32'h0,        N, N, BAD,          N, N, N, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(Y, N, Y, N, 32'h8000,    32'h0,        N, N, BAD,          Y, N, N, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(Y, N, Y, N, 32'h8000,    32'h0,        N, N, BAD,          Y, N, N, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        Y, N, BAD,          N, N, N, 32'h1000,    32'h12345678, 32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        Y, N, BAD,          N, Y, N, 32'h3000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        Y, N, BAD,          N, Y, N, 32'h3000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        Y, N, BAD,          N, Y, N, 32'h3000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        N, N, BAD,          N, Y, N, 32'h3000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        N, N, BAD,          N, N, N, 32'h3000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        N, Y, 32'hCAFEF00D, N, N, N, 32'h3000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h3000,    32'h0,        N, N, BAD,          Y, N, N, 32'h3000,    32'h0,        32'hCAFEF00D, N));
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h3000,    32'h0,        32'hCAFEF00D, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h4000,    32'h0,        N, N, BAD,          N, N, N, 32'h3000,    32'h0,        32'hCAFEF00D, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h4000,    32'h0,        N, N, BAD,          N, Y, N, 32'h4000,    32'h0,        32'hCAFEF00D, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h4000,    32'h0,        N, Y, 32'h11223344, N, N, N, 32'h4000,    32'h0,        32'hCAFEF00D, N));
    vq.push_back(mk(N, Y, Y, N, 32'h4000,    32'h0,        N, N, BAD,          N, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(N, Y, Y, N, 32'h4000,    32'h0,        N, Y, 32'h77777777, N, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(N, Y, Y, N, 32'h4000,    32'h0,        N, N, BAD,          N, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(N, Y, Y, N, 32'h4000,    32'h0,        N, N, BAD,          N, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(N, Y, Y, N, 32'h4000,    32'h0,        N, N, BAD,          N, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h4000,    32'h0,        N, N, BAD,          Y, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, N, BAD,          N, N, N, 32'h4000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, N, BAD,          N, Y, N, 32'h2000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, Y, 32'hA5A50001, N, N, N, 32'h2000,    32'h0,        32'h11223344, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, N, BAD,          Y, N, N, 32'h2000,    32'h0,        32'hA5A50001, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, N, BAD,          N, N, N, 32'h2000,    32'h0,        32'hA5A50001, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, N, BAD,          N, Y, N, 32'h2000,    32'h0,        32'hA5A50001, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, Y, 32'hA5A50002, N, N, N, 32'h2000,    32'h0,        32'hA5A50001, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h2000,    32'h0,        N, N, BAD,          Y, N, N, 32'h2000,    32'h0,        32'hA5A50002, N));
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h2000,    32'h0,        32'hA5A50002, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h9000,    32'h0,        N, N, BAD,          N, N, N, 32'h2000,    32'h0,        32'hA5A50002, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h9000,    32'h0,        N, Y, 32'h600DF00D, N, Y, N, 32'h9000,    32'h0,        32'hA5A50002, N));
    vq.push_back(mk(Y, Y, Y, N, 32'h9000,    32'h0,        N, N, BAD,          Y, N, N, 32'h9000,    32'h0,        32'h600DF00D, N));
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h9000,    32'h0,        32'h600DF00D, N));
    run_table("main");

    // Timeout: waitrequest stuck high on a read, strobe must last exactly 8 cycles.
    @(posedge clk); #1;
    cpu_data_read = 1'b1; cpu_data_address = 32'h6000; bus.avm_waitrequest = 1'b1;
    #1;
    check1("to_idle.clk_enable", cpu_clk_enable, N);
    check1("to_idle.avm_read", bus.avm_read, N);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      check1($sformatf("to_req%0d.avm_read", i), bus.avm_read, Y);
      check1($sformatf("to_req%0d.clk_enable", i), cpu_clk_enable, N);
    end
    @(posedge clk); #2;
    check1("to_done.avm_read", bus.avm_read, N);
    check1("to_done.clk_enable", cpu_clk_enable, Y);
    check("to_done.readdata", cpu_data_readdata, 32'hDEADBEEF);
    check1("to_done.bus_error", bus_error, Y);
    @(posedge clk); #1;
    cpu_data_read = 1'b0; bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1($sformatf("to_sticky%0d.bus_error", i), bus_error, Y);
      check1($sformatf("to_sticky%0d.avm_read", i), bus.avm_read, N);
      @(posedge clk); #1;
    end

    // Asynchronous reset while waiting for read data, then stray readdatavalid.
    cpu_data_read = 1'b1; cpu_data_address = 32'h7000;
    @(posedge clk); #2;
    check1("rr_req.avm_read", bus.avm_read, Y);
    @(posedge clk); #2;
    check1("rr_wait.avm_read", bus.avm_read, N);
    check1("rr_wait.clk_enable", cpu_clk_enable, N);
    #2 reset_n = 1'b0;
    #1;
    check1("rr_rst.clk_enable", cpu_clk_enable, N);
    check1("rr_rst.avm_read", bus.avm_read, N);
    check("rr_rst.avm_address", bus.avm_address, 32'h0);
    check("rr_rst.readdata", cpu_data_readdata, 32'h0);
    check1("rr_rst.bus_error", bus_error, N);
    cpu_data_read = 1'b0;
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'h99999999;
    @(posedge clk); #2;
    check1("rr_held.clk_enable", cpu_clk_enable, N);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      check($sformatf("rr_stray%0d.readdata", i), cpu_data_readdata, 32'h0);
      check1($sformatf("rr_stray%0d.avm_read", i), bus.avm_read, N);
      check1($sformatf("rr_stray%0d.clk_enable", i), cpu_clk_enable, Y);
    end
    bus.avm_readdatavalid = 1'b0;

    // Simultaneous read+write after a normal read: write only, hold cleared, error set.
    //                    ext act rd wr addr          wd            wt rv rdat            en rd wr e_addr        e_wd          e_rdata       err
    vq.push_back(mk(Y, Y, Y, N, 32'h5000,    32'h0,        N, N, BAD,          N, N, N, 32'h0,       32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h5000,    32'h0,        N, N, BAD,          N, Y, N, 32'h5000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h5000,    32'h0,        N, Y, 32'h13572468, N, N, N, 32'h5000,    32'h0,        32'h0,        N));
    vq.push_back(mk(Y, Y, Y, N, 32'h5000,    32'h0,        N, N, BAD,          Y, N, N, 32'h5000,    32'h0,        32'h13572468, N));
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h5000,    32'h0,        32'h13572468, N));
    vq.push_back(mk(Y, Y, Y, Y, 32'h5004,    32'h0F0F0F0F, N, N, BAD,          N, N, N, 32'h5000,    32'h0,        32'h13572468, N));
    vq.push_back(mk(Y, Y, Y, Y, 32'h5004,    32'h0F0F0F0F, N, N, BAD,          N, N, Y, 32'h5004,    32'h0F0F0F0F, 32'h0,        Y));
    vq.push_back(mk(Y, Y, Y, Y, 32'h5004,    32'h0F0F0F0F, N, N, BAD,          Y, N, N, 32'h5004,    32'h0F0F0F0F, 32'h0,        Y));
    vq.push_back(mk(Y, Y, N, N, 32'h0,       32'h0,        N, N, BAD,          Y, N, N, 32'h5004,    32'h0F0F0F0F, 32'h0,        Y));
    run_table("rdwr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
